ro_freq_meter: RTL and testbench

//  Measures the ring-oscillator output frequency inside the RO tile.

---
 rtl/ro_freq_meter.sv | 157 +++++++++++++++
 tb/tb_ro_freq_meter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized RO rising edges over a 2^N clk window.
// Optional RO_MEAS_CONTINUOUS_EN: back-to-back windows while start is held, done pulses per window.
module ro_freq_meter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int WIN_MIN     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             start,
  input  logic [3:0]       win_log2,
  input  logic [1:0]       rd_sel,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] result,
  output logic [7:0]       byte_out
);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

  localparam logic [3:0]  WIN_MIN_L = 4'(WIN_MIN);
  localparam logic [15:0] SET_LAST  = 16'(SYNC_STAGES - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [3:0]             win_n_q, win_n_d;
  logic [15:0]            win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   ovf_int_q, ovf_int_d;
  logic [CNT_W-1:0]       result_q, result_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   ro_edge;
  logic                   cnt_max;
  logic [CNT_W-1:0]       cnt_next;
  logic                   ovf_next;
  logic [15:0]            win_last;
  logic [3:0]             win_clamp;
  logic [23:0]            res_ext;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], ro_in};
    prev_d    = sync_q[SYNC_STAGES-1];
    ro_edge   = sync_q[SYNC_STAGES-1] & ~prev_q;
    cnt_max   = (edge_cnt_q == {CNT_W{1'b1}});
    cnt_next  = (ro_edge && !cnt_max) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    ovf_next  = ovf_int_q | (ro_edge & cnt_max);
    win_last  = (16'd1 << win_n_q) - 16'd1;
    win_clamp = (win_log2 < WIN_MIN_L) ? WIN_MIN_L : win_log2;

    state_d    = state_q;
    win_n_d    = win_n_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_int_d  = ovf_int_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == IDLE) done_d = 1'b0;
        if (start) begin
          state_d    = SETTLE;
          win_n_d    = win_clamp;
          win_cnt_d  = '0;
          edge_cnt_d = '0;
          ovf_int_d  = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      // Settle lets stale synchronizer contents drain before counting.
      SETTLE: begin
        win_cnt_d = win_cnt_q + 16'd1;
        if (win_cnt_q == SET_LAST) begin
          state_d   = COUNT;
          win_cnt_d = '0;
        end
      end
      COUNT: begin
        edge_cnt_d = cnt_next;
        ovf_int_d  = ovf_next;
        win_cnt_d  = win_cnt_q + 16'd1;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        if (win_cnt_q == win_last) begin
          result_d   = cnt_next;
          overflow_d = ovf_next;
          edge_cnt_d = '0;
          ovf_int_d  = 1'b0;
          win_cnt_d  = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
`ifdef RO_MEAS_CONTINUOUS_EN
          state_d    = start ? COUNT : IDLE;
`else
          state_d    = DONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      win_n_q    <= WIN_MIN_L;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      ovf_int_q  <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      win_n_q    <= win_n_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_int_q  <= ovf_int_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Zero-extend so bytes beyond CNT_W read back as 0.
  always_comb begin
    res_ext = '0;
    res_ext[CNT_W-1:0] = result_q;
    case (rd_sel)
      2'd0:    byte_out = res_ext[7:0];
      2'd1:    byte_out = res_ext[15:8];
      2'd2:    byte_out = res_ext[23:16];
      default: byte_out = {busy_q, done_q, overflow_q, 5'b0};
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign result   = result_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: timeline/arithmetic model checked every cycle, plus literal pins.
module tb_ro_freq_meter;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n, ro_in, start;
  logic [3:0]  win_log2;
  logic [1:0]  rd_sel;
  logic        busy, done, overflow;
  logic [23:0] result;
  logic [7:0]  byte_out;
  logic        busy4, done4, overflow4;
  logic [3:0]  result4;
  logic [7:0]  byte_out4;

  int tests = 0;
  int fails = 0;
  int ro_per = 0;
  bit sel_auto = 1'b1;

  ro_freq_meter #(.CNT_W(24), .SYNC_STAGES(S), .WIN_MIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .win_log2(win_log2),
    .rd_sel(rd_sel), .busy(busy), .done(done), .overflow(overflow),
    .result(result), .byte_out(byte_out));

  ro_freq_meter #(.CNT_W(4), .SYNC_STAGES(S), .WIN_MIN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .win_log2(win_log2),
    .rd_sel(rd_sel), .busy(busy4), .done(done4), .overflow(overflow4),
    .result(result4), .byte_out(byte_out4));

  always #5 clk = ~clk;

  // Square-wave RO stand-in; period in clk cycles, 0 holds it low.
  initial begin
    int ph;
    ph = 0;
    ro_in = 1'b0;
    forever begin
      @(negedge clk);
      ph = ph + 1;
      ro_in = (ro_per != 0) && ((ph % ro_per) < (ro_per / 2));
    end
  end

  function automatic int win_len(input logic [3:0] w);
    return 1 << ((w < 4) ? 4 : int'(w));
  endfunction

  function automatic int edges_in_window(input logic [3:0] w, input int per);
    return (per == 0) ? 0 : win_len(w) / per;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [1:0] s, input logic [23:0] r,
                                          input bit b, input bit d, input bit o);
    case (s)
      2'd0:    return r[7:0];
      2'd1:    return r[15:8];
      2'd2:    return r[23:16];
      default: return {b, d, o, 5'b0};
    endcase
  endfunction

  // Model: a run accepted at posedge P completes at posedge P+S+2^N.
  bit          m_run, exp_busy, exp_done, exp_ovf, exp_ovf4, pend_ovf, pend_ovf4;
  int          pc, run_end, m_len;
  logic [23:0] exp_res, pend_res;
  logic [3:0]  exp_res4, pend_res4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; exp_busy <= 0; exp_done <= 0; exp_ovf <= 0; exp_ovf4 <= 0;
      pend_ovf <= 0; pend_ovf4 <= 0; pc <= 0; run_end <= 0; m_len <= 0;
      exp_res <= '0; pend_res <= '0; exp_res4 <= '0; pend_res4 <= '0;
    end else begin
      pc <= pc + 1;
      if (m_run && (pc + 1 == run_end)) begin
        exp_res  <= pend_res;  exp_ovf  <= pend_ovf;
        exp_res4 <= pend_res4; exp_ovf4 <= pend_ovf4;
        exp_busy <= 0;
        exp_done <= 1;
`ifdef RO_MEAS_CONTINUOUS_EN
        if (start) run_end <= run_end + m_len;
        else       m_run   <= 0;
`else
        m_run <= 0;
`endif
      end else if (!m_run && start) begin
        m_run     <= 1;
        m_len     <= win_len(win_log2);
        run_end   <= pc + 1 + S + win_len(win_log2);
        exp_busy  <= 1;
        exp_done  <= 0;
        pend_res  <= (edges_in_window(win_log2, ro_per) > 24'hFFFFFF) ? 24'hFFFFFF
                     : 24'(edges_in_window(win_log2, ro_per));
        pend_ovf  <= edges_in_window(win_log2, ro_per) > 24'hFFFFFF;
        pend_res4 <= (edges_in_window(win_log2, ro_per) > 15) ? 4'hF
                     : 4'(edges_in_window(win_log2, ro_per));
        pend_ovf4 <= edges_in_window(win_log2, ro_per) > 15;
      end else if (m_run) begin
        exp_busy <= 1;
        exp_done <= 0;
      end else begin
`ifdef RO_MEAS_CONTINUOUS_EN
        exp_done <= 0;
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("busy",      32'(busy),      32'(exp_busy));
    chk("done",      32'(done),      32'(exp_done));
    chk("overflow",  32'(overflow),  32'(exp_ovf));
    chk("result",    32'(result),    32'(exp_res));
    chk("byte_out",  32'(byte_out),  32'(exp_byte(rd_sel, exp_res, exp_busy, exp_done, exp_ovf)));
    chk("busy4",     32'(busy4),     32'(exp_busy));
    chk("done4",     32'(done4),     32'(exp_done));
    chk("overflow4", 32'(overflow4), 32'(exp_ovf4));
    chk("result4",   32'(result4),   32'(exp_res4));
    chk("byte_out4", 32'(byte_out4), 32'(exp_byte(rd_sel, {20'd0, exp_res4}, exp_busy, exp_done, exp_ovf4)));
    chk("busy_done_excl", 32'(busy & done), 32'd0);
    if (sel_auto) rd_sel = rd_sel + 2'd1;
  endtask

  task automatic wait_done(inout int nb);
    for (int i = 0; i < 1000; i++) begin
      tick();
      nb += int'(busy);
      if (done) break;
    end
    chk("wait_done", 32'(done), 32'd1);
  endtask

  // Start pulse, then scramble win_log2 to show mid-run changes are ignored.
  task automatic run(input logic [3:0] w, output int nb);
    win_log2 = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    win_log2 = 4'hF;
    nb = int'(busy);
    wait_done(nb);
  endtask

  initial begin
    int nb;
    int np;
    rst_n = 1'b0; start = 1'b0; win_log2 = 4'd0; rd_sel = 2'd0;
    repeat (4) tick();
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_busy",   32'(busy),   32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Period 8 over a 256-cycle window.
    ro_per = 8;
    repeat (6) tick();
    run(4'd8, nb);
    chk("t2_busy_cycles", 32'(nb), 32'd258);
    chk("t2_result", 32'(result), 32'd32);
    chk("t2_overflow", 32'(overflow), 32'd0);

    // Exponent 2 clamps to a 16-cycle window.
    ro_per = 4;
    repeat (6) tick();
    run(4'd2, nb);
    chk("t3_busy_cycles", 32'(nb), 32'd18);
    chk("t3_result", 32'(result), 32'd4);
    ro_per = 0;
    repeat (6) tick();
    run(4'd2, nb);
    chk("t3_result_quiet", 32'(result), 32'd0);

    // 64 edges saturate the 4-bit instance.
    ro_per = 4;
    repeat (6) tick();
    run(4'd8, nb);
    chk("t4_result4", 32'(result4), 32'd15);
    chk("t4_overflow4", 32'(overflow4), 32'd1);
    chk("t4_result24", 32'(result), 32'd64);
    sel_auto = 1'b0;
    rd_sel = 2'd3;
    #1;
    chk("t4_status4", 32'(byte_out4), 32'h60);
    sel_auto = 1'b1;

    // Start during COUNT is ignored; start from DONE restarts.
    ro_per = 8;
    repeat (6) tick();
    win_log2 = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_still_busy", 32'(busy), 32'd1);
    chk("t5_result_hold", 32'(result), 32'd64);
    nb = 0;
    wait_done(nb);
    chk("t5_result", 32'(result), 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_restart_done", 32'(done), 32'd0);
    chk("t5_restart_busy", 32'(busy), 32'd1);
    nb = 0;
    wait_done(nb);

    // Asynchronous reset in the middle of a COUNT window.
    win_log2 = 4'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    sel_auto = 1'b0;
    rd_sel = 2'd3;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    chk("t1_result", 32'(result), 32'd0);
    chk("t1_status", 32'(byte_out), 32'h00);
    chk("t1_status4", 32'(byte_out4), 32'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    sel_auto = 1'b1;
    repeat (4) tick();

`ifdef RO_MEAS_CONTINUOUS_EN
    // Continuous windows: one done pulse per 16 cycles, 2 edges each.
    ro_per = 8;
    win_log2 = 4'd4;
    start = 1'b1;
    repeat (20) tick();
    np = 0;
    repeat (64) begin
      tick();
      if (done) begin
        np++;
        chk("t6_result", 32'(result), 32'd2);
      end
    end
    chk("t6_pulses", 32'(np), 32'd4);
    start = 1'b0;
    repeat (40) tick();
    chk("t6_idle", 32'(busy), 32'd0);
`else
    np = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
